pe_buffer_fill_ctrl: RTL and testbench
======================================

Name: pe_buffer_fill_ctrl

Overview:
Controller that sequences writes into a PE's circular input register file (NUM_OF_REG entries) from an upstream valid/ready source, then hands each full window to the PE.
- Initial fill writes all NUM_OF_REG entries.
- After each pe_done, refills only `stride` entries, reusing the overlapping window.
- Sits between the input FIFO and the PE datapath; it owns the register-file write address and the PE start/done handshake.

Parameters:
NUM_OF_REG, 12, number of register-file entries (window size); must be >= 2
ADDR_W, 4, width of wr_addr/win_base; must satisfy 2**ADDR_W >= NUM_OF_REG
WIN_W, 8, width of the window-count configuration

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a job; honoured only in IDLE
cfg_stride  in  ADDR_W  entries replaced per window advance; latched on accepted start
cfg_num_windows  in  WIN_W  windows to process; latched on accepted start
src_valid  in  1  upstream data valid
src_ready  out  1  controller accepts a source word this cycle
wr_en  out  1  register-file write strobe
wr_addr  out  ADDR_W  register-file write address
win_base  out  ADDR_W  address of oldest entry of current window (PE read base)
pe_start  out  1  one-cycle pulse: window complete, PE may compute
pe_done  in  1  PE finished current window
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when job completes

Behaviour:
- Reset (async, rst=1): state=IDLE; wr_ptr, win_base, fill_cnt and win_cnt = 0; src_ready, wr_en, pe_start, busy and done = 0.
- Reset mid-job: abandons the job immediately; buffer contents are invalid; no done pulse.
- Stride clamp: cfg_stride==0 or cfg_stride>NUM_OF_REG is latched as NUM_OF_REG.
- States and transitions:
  - IDLE:
    - start=1 and cfg_num_windows!=0 -> FILL, with fill_target=NUM_OF_REG, fill_cnt=0, win_base=0, wr_ptr=0.
    - start=1 and cfg_num_windows==0 -> DONE, with no writes.
  - FILL:
    - src_ready=1.
    - wr_en = src_valid & src_ready (combinational); wr_addr=wr_ptr.
    - On each write: wr_ptr advances mod NUM_OF_REG (NUM_OF_REG-1 wraps to 0) and fill_cnt increments.
    - The write that makes fill_cnt==fill_target moves to COMPUTE. src_ready is 0 from the next cycle, so no extra word is accepted.
  - COMPUTE:
    - pe_start=1 in the first COMPUTE cycle only; src_ready=0.
    - pe_done is sampled every COMPUTE cycle, including the first.
    - On pe_done: win_cnt increments, win_base advances by stride mod NUM_OF_REG.
      - If win_cnt+1 == num_windows -> DONE.
      - Otherwise -> FILL with fill_target=stride, fill_cnt=0.
  - DONE: done=1 for one cycle, then IDLE.
- Handshake rules:
  - pe_done outside COMPUTE is ignored.
  - start outside IDLE is ignored, and config is not re-latched.
  - src_valid with src_ready=0 produces no write.
  - The source may hold or drop src_valid freely.
- Latency:
  - First write occurs no earlier than the cycle after start.
  - pe_start occurs the cycle after the last fill write.
  - Minimum job time is NUM_OF_REG+1 cycles to the first pe_start.
- Wrap rule: wr_ptr after a refill always equals win_base mod NUM_OF_REG. This invariant is checked by an assertion.
- busy = (state != IDLE); done is not asserted together with busy=0 in the same cycle.

Decomposition:
- Shared package: state enum (IDLE, FILL, COMPUTE, DONE) and a clamp_stride function.
- Sub-module mod_n_ptr:
  - Parameters NUM_OF_REG and ADDR_W.
  - Ports: clk, rst, clr, add_en, add_val; output ptr.
  - Computes ptr+add_val wrapped mod NUM_OF_REG.
  - Instantiated twice: wr_ptr with add_val=1, and win_base with add_val=stride.

Test Plan:
1. Basic job (NUM_OF_REG=12, stride=1, num_windows=3, src_valid held 1) -> 12 writes at addr 0..11; pe_start; pe_done -> 1 write at addr 0 with win_base=1; pe_done -> 1 write at addr 1 with win_base=2; pe_done -> done pulse; total 14 writes.
2. Backpressure (stride=4, num_windows=2, src_valid toggling 1/0) -> writes only on valid cycles; refill writes addr 0..3; win_base=4; no wr_en while in COMPUTE.
3. Wrap and clamp:
   - stride=5, num_windows=4 -> win_base sequence 0, 5, 10, 3; refill addrs 0-4, 5-9, then 10, 11, 0, 1, 2.
   - stride=0 -> behaves as 12 (full refill each window).
4. Edge config and ignored inputs:
   - num_windows=0 -> done the cycle after start; zero writes.
   - start pulsed while busy -> ignored.
   - pe_done asserted during FILL -> ignored.
5. pe_done in the same cycle as pe_start -> accepted; next state FILL; win_base advances once.
6. rst asserted mid-FILL after 7 writes -> outputs 0 asynchronously; a new start restarts from addr 0 with 12 writes.

Source files
------------

// File: rtl/pe_buffer_fill_ctrl_pkg.sv
// Shared types and helpers for the PE register-file fill controller.
package pe_buffer_fill_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_COMPUTE,
    S_DONE
  } state_t;

  // A zero or oversized stride degenerates to a full-window refill.
  function automatic int unsigned clamp_stride(input int unsigned stride,
                                               input int unsigned num_of_reg);
    return (stride == 0 || stride > num_of_reg) ? num_of_reg : stride;
  endfunction

endpackage

// File: rtl/pe_buffer_fill_ctrl_if.sv
// Configuration, source handshake, register-file write and PE handshake bundle.
interface pe_buffer_fill_ctrl_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned WIN_W  = 8
) ();

  logic              start;
  logic [ADDR_W-1:0] cfg_stride;
  logic [WIN_W-1:0]  cfg_num_windows;
  logic              src_valid;
  logic              src_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] win_base;
  logic              pe_start;
  logic              pe_done;
  logic              busy;
  logic              done;

  modport master (
    output start, cfg_stride, cfg_num_windows, src_valid, pe_done,
    input  src_ready, wr_en, wr_addr, win_base, pe_start, busy, done
  );

  modport slave (
    input  start, cfg_stride, cfg_num_windows, src_valid, pe_done,
    output src_ready, wr_en, wr_addr, win_base, pe_start, busy, done
  );

endinterface

// File: rtl/pe_buffer_fill_ctrl_mod_n_ptr.sv
// Pointer register that advances by add_val, wrapping modulo NUM_OF_REG.
module mod_n_ptr #(
  parameter int unsigned NUM_OF_REG = 12,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add_en,
  input  logic [ADDR_W:0]   add_val,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W+1:0] MODULUS = (ADDR_W+2)'(NUM_OF_REG);

  logic [ADDR_W+1:0] sum;
  logic [ADDR_W-1:0] next_ptr;

  // ptr < NUM_OF_REG and add_val <= NUM_OF_REG, so one conditional subtract wraps.
  always_comb begin
    sum      = {2'b00, ptr} + {1'b0, add_val};
    next_ptr = ADDR_W'((sum >= MODULUS) ? (sum - MODULUS) : sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (add_en) begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/pe_buffer_fill_ctrl.sv
// Sequences source words into the PE's circular register file: a full initial
// fill, then a stride-sized refill after every pe_done, handing each window to the PE.
module pe_buffer_fill_ctrl
  import pe_buffer_fill_ctrl_pkg::*;
#(
  parameter int unsigned NUM_OF_REG = 12,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned WIN_W      = 8
) (
  input logic                  clk,
  input logic                  rst,
  pe_buffer_fill_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(NUM_OF_REG);

  state_t            state;
  logic [ADDR_W:0]   stride;
  logic [ADDR_W:0]   fill_target;
  logic [ADDR_W:0]   fill_cnt;
  logic [WIN_W-1:0]  num_windows;
  logic [WIN_W-1:0]  win_cnt;
  logic              src_ready;
  logic              pe_start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] win_base;

  logic start_accept;
  logic wr_en;
  logic window_done;
  logic fill_last;

  // NOTE: wr_en is combinational so a word is written in the same cycle it is
  // accepted; src_ready itself is registered and drops right after the last write.
  assign start_accept = (state == S_IDLE) && bus.start;
  assign wr_en        = bus.src_valid && src_ready;
  assign window_done  = (state == S_COMPUTE) && bus.pe_done;
  assign fill_last    = (fill_cnt + (ADDR_W+1)'(1)) == fill_target;

  mod_n_ptr #(.NUM_OF_REG(NUM_OF_REG), .ADDR_W(ADDR_W)) u_wr_ptr (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_accept),
    .add_en  (wr_en),
    .add_val ((ADDR_W+1)'(1)),
    .ptr     (wr_ptr)
  );

  mod_n_ptr #(.NUM_OF_REG(NUM_OF_REG), .ADDR_W(ADDR_W)) u_win_base (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_accept),
    .add_en  (window_done),
    .add_val (stride),
    .ptr     (win_base)
  );

  // NOTE: all state is updated with non-blocking assignments so every branch
  // reads the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      stride      <= '0;
      fill_target <= '0;
      fill_cnt    <= '0;
      num_windows <= '0;
      win_cnt     <= '0;
      src_ready   <= 1'b0;
      pe_start    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            stride      <= (ADDR_W+1)'(clamp_stride(32'(bus.cfg_stride), NUM_OF_REG));
            num_windows <= bus.cfg_num_windows;
            fill_target <= FULL;
            fill_cnt    <= '0;
            win_cnt     <= '0;
            busy        <= 1'b1;
            if (bus.cfg_num_windows != '0) begin
              state     <= S_FILL;
              src_ready <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_FILL: begin
          if (wr_en) begin
            fill_cnt <= fill_cnt + (ADDR_W+1)'(1);
            if (fill_last) begin
              state     <= S_COMPUTE;
              src_ready <= 1'b0;
              pe_start  <= 1'b1;
            end
          end
        end

        S_COMPUTE: begin
          pe_start <= 1'b0;
          if (bus.pe_done) begin
            win_cnt <= win_cnt + WIN_W'(1);
            if ((win_cnt + WIN_W'(1)) == num_windows) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state       <= S_FILL;
              fill_target <= stride;
              fill_cnt    <= '0;
              src_ready   <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.src_ready = src_ready;
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = wr_ptr;
  assign bus.win_base  = win_base;
  assign bus.pe_start  = pe_start;
  assign bus.busy      = busy;
  assign bus.done      = done;

  // Every completed fill leaves the write pointer on the oldest entry of the window.
  wr_ptr_tracks_base: assert property (
    @(posedge clk) disable iff (rst) (state == S_COMPUTE) |-> (wr_ptr == win_base)
  );

endmodule

// File: tb/tb_pe_buffer_fill_ctrl.sv
// Directed bench: a job-level event model predicts every write, pe_start and done.
module tb_pe_buffer_fill_ctrl;

  localparam int N  = 12;
  localparam int AW = 4;
  localparam int WW = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pe_buffer_fill_ctrl_if #(.ADDR_W(AW), .WIN_W(WW)) bus ();

  pe_buffer_fill_ctrl #(.NUM_OF_REG(N), .ADDR_W(AW), .WIN_W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum int {EV_WR, EV_PS, EV_DN} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       addr;
    int       base;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  n_wr = 0;
  int  last_ps_base = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(input ev_kind_t k, input int a, input int b);
    exp_q.push_back('{kind: k, addr: a, base: b});
  endfunction

  // Job model: window k (k>=1) is refilled with eff entries starting where the
  // previous fill ended, and is read from base k*eff mod N.
  function automatic void plan_job(input int s, input int nw);
    int eff;
    eff = (s == 0 || s > N) ? N : s;
    if (nw != 0) begin
      for (int i = 0; i < N; i++) push(EV_WR, i, 0);
      push(EV_PS, 0, 0);
      for (int k = 1; k < nw; k++) begin
        for (int i = 0; i < eff; i++) push(EV_WR, ((k - 1) * eff + i) % N, (k * eff) % N);
        push(EV_PS, 0, (k * eff) % N);
      end
    end
    push(EV_DN, 0, (nw * eff) % N);
  endfunction

  task automatic expect_event(input ev_kind_t k, input int addr, input int base);
    ev_t e;
    check("event_expected", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      if (k == EV_WR) check("wr_addr", addr, e.addr);
      check("win_base", base, e.base);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en) begin
        n_wr++;
        check("wr_en_needs_ready", bus.src_ready, 1);
        expect_event(EV_WR, int'(bus.wr_addr), int'(bus.win_base));
      end
      if (bus.pe_start) begin
        last_ps_base = int'(bus.win_base);
        expect_event(EV_PS, 0, int'(bus.win_base));
      end
      if (bus.done) begin
        check("done_with_busy", bus.busy, 1);
        expect_event(EV_DN, 0, int'(bus.win_base));
      end
    end
  end

  // vmode 0: src_valid held high; 1: toggles. pdd: cycles from pe_start to pe_done.
  // noise: start pulses while busy and pe_done during fill. abort_wr>0: reset after that many writes.
  task automatic run_job(input int s, input int nw, input int vmode, input int pdd,
                         input bit noise, input int abort_wr,
                         output int first_ps, output int done_cyc, output int writes);
    int  w0;
    int  cnt;
    bit  waiting;
    w0       = n_wr;
    cnt      = 0;
    waiting  = 1'b0;
    first_ps = -1;
    done_cyc = -1;
    plan_job(s, nw);
    bus.cfg_stride      = AW'(s);
    bus.cfg_num_windows = WW'(nw);
    bus.start           = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (abort_wr > 0 && (n_wr - w0) >= abort_wr) begin
        #2 rst = 1'b1;
        #1;
        check("rst_src_ready", bus.src_ready, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_win_base", bus.win_base, 0);
        check("rst_pe_start", bus.pe_start, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        exp_q.delete();
        bus.src_valid = 1'b0;
        bus.pe_done   = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        writes = n_wr - w0;
        return;
      end
      check("busy_during_job", bus.busy, 1);
      if (bus.pe_start && first_ps < 0) first_ps = c;
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      if (bus.pe_start) begin
        waiting = 1'b1;
        cnt     = pdd;
      end
      if (waiting && cnt == 0) begin
        bus.pe_done = 1'b1;
        waiting     = 1'b0;
      end else begin
        bus.pe_done = noise && bus.src_ready;
        if (waiting) cnt--;
      end
      bus.src_valid = (vmode == 0) ? 1'b1 : ((c % 2) == 1);
      if (noise && (c % 3) == 0) begin
        bus.start           = 1'b1;
        bus.cfg_num_windows = '0;
        bus.cfg_stride      = AW'(7);
      end
    end
    bus.start     = 1'b0;
    bus.pe_done   = 1'b0;
    bus.src_valid = 1'b0;
    check("job_completed", done_cyc > 0, 1);
    writes = n_wr - w0;
    @(posedge clk);
    #1;
    check("idle_busy_low", bus.busy, 0);
    check("idle_done_low", bus.done, 0);
  endtask

  initial begin
    int fp, dc, w;
    rst                 = 1'b1;
    bus.start           = 1'b0;
    bus.cfg_stride      = '0;
    bus.cfg_num_windows = '0;
    bus.src_valid       = 1'b0;
    bus.pe_done         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_src_ready", bus.src_ready, 0);
    check("reset_wr_en", bus.wr_en, 0);
    check("reset_wr_addr", bus.wr_addr, 0);
    check("reset_win_base", bus.win_base, 0);
    check("reset_pe_start", bus.pe_start, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_job(1, 3, 0, 2, 1'b0, 0, fp, dc, w);
    check("basic_writes", w, 14);
    check("basic_first_pe_start", fp, 13);
    check("basic_last_base", last_ps_base, 2);

    run_job(4, 2, 1, 1, 1'b0, 0, fp, dc, w);
    check("backpressure_writes", w, 16);
    check("backpressure_base", last_ps_base, 4);

    run_job(5, 4, 0, 0, 1'b0, 0, fp, dc, w);
    check("wrap_writes", w, 27);
    check("wrap_last_base", last_ps_base, 3);

    run_job(0, 2, 0, 1, 1'b0, 0, fp, dc, w);
    check("clamp_writes", w, 24);
    check("clamp_base", last_ps_base, 0);
    check("clamp_first_pe_start", fp, 13);

    run_job(3, 0, 0, 0, 1'b0, 0, fp, dc, w);
    check("zero_windows_writes", w, 0);
    check("zero_windows_done_cycle", dc, 1);

    run_job(2, 3, 0, 1, 1'b1, 0, fp, dc, w);
    check("ignored_inputs_writes", w, 16);
    check("ignored_inputs_base", last_ps_base, 4);

    run_job(3, 2, 0, 0, 1'b0, 0, fp, dc, w);
    check("same_cycle_done_writes", w, 15);
    check("same_cycle_done_base", last_ps_base, 3);

    run_job(1, 1, 0, 0, 1'b0, 7, fp, dc, w);
    check("abort_writes", w, 7);
    run_job(12, 1, 0, 0, 1'b0, 0, fp, dc, w);
    check("restart_writes", w, 12);
    check("restart_first_pe_start", fp, 13);
    check("restart_base", last_ps_base, 0);

    check("leftover_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
